// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

    localparam int KP_ROWS  = 4;
    localparam int KP_COLS  = 4;
    localparam int KEYS     = KP_ROWS * KP_COLS;
    localparam int KEY_W    = $clog2(KEYS);
    // Helpers work on a fixed-width vector; matrices up to 8x8 fit.
    localparam int MAX_KEYS = 64;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_PRESSED = 2'd1,
        KP_MULTI   = 2'd2
    } kp_state_e;

    // Number of keys down in a (zero-extended) matrix.
    function automatic int kp_popcount(input logic [MAX_KEYS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Index of the lowest key down; only meaningful when exactly one is set.
    function automatic int kp_low_index(input logic [MAX_KEYS-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Frame-level debouncer: the output matrix follows the snapshot only after
// DEBOUNCE consecutive frame-end comparisons found it unchanged.
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int W        = KEYS,
    parameter int DEBOUNCE = 20
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] snap_i,
    input  logic         frame_end_i,
    output logic [W-1:0] deb_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [W-1:0]  prev_q;
    logic [W-1:0]  deb_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Stable-frame count: saturating increment on a match, clear on a change.
    always_comb begin
        cnt_d = cnt_q;
        if (snap_i == prev_q) begin
            if (cnt_q != CW'(DEBOUNCE)) cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Compare, remember and (once stable long enough) commit at each frame end.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
            deb_q  <= '0;
            cnt_q  <= '0;
        end else if (frame_end_i) begin
            cnt_q  <= cnt_d;
            prev_q <= snap_i;
            if (cnt_d == CW'(DEBOUNCE)) deb_q <= snap_i;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 (parameterisable) matrix keypad scanner: drives one row low at a time,
// samples the column returns, debounces whole frames and reports single-key
// presses over a valid/ready handshake.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = KP_ROWS,
    parameter int COLS     = KP_COLS,
    parameter int SCAN_DIV = 100_000,
    parameter int DEBOUNCE = 20
) (
    input  logic                           CLK100MHZ,
    input  logic                           CPU_RESET,
    output logic [ROWS-1:0]                ROW,
    input  logic [COLS-1:0]                COL,
    output logic [$clog2(ROWS*COLS)-1:0]   key_code,
    output logic                           key_valid,
    input  logic                           key_ready,
    output logic                           multi,
    output logic                           overflow
);

    localparam int KEYS_N = ROWS * COLS;
    localparam int KW     = $clog2(KEYS_N);
    localparam int DW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [1:0] ST_IDLE    = KP_IDLE;
    localparam logic [1:0] ST_PRESSED = KP_PRESSED;
    localparam logic [1:0] ST_MULTI   = KP_MULTI;

    logic [COLS-1:0]     col_s1_q, col_s2_q;
    logic [DW-1:0]       dwell_q;
    logic [RW-1:0]       row_idx_q;
    logic [RW-1:0]       row_next;
    logic [ROWS-1:0]     row_q;
    logic [KEYS_N-1:0]   snap_q;
    logic                frame_end_q;
    logic [KEYS_N-1:0]   deb;
    logic [MAX_KEYS-1:0] deb_ext;
    logic                dwell_last, row_last;
    logic [1:0]          state_q, state_d;
    logic                press;
    logic                accept;
    logic [KW-1:0]       code_q;
    logic                valid_q;
    logic                ovf_q;
    int                  n_down;
    int                  down_idx;

    assign dwell_last = (dwell_q == DW'(SCAN_DIV - 1));
    assign row_last   = (row_idx_q == RW'(ROWS - 1));
    assign row_next   = row_last ? '0 : row_idx_q + RW'(1);

    // Two-flop synchroniser for the asynchronous, active-low column returns.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
        end else begin
            col_s1_q <= COL;
            col_s2_q <= col_s1_q;
        end
    end

    // Row scan: sample on the last dwell cycle (covers sync latency and
    // settling), then move the row drive. frame_end_q trails the last sample
    // by one cycle so the debouncer sees the completed snapshot.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            dwell_q     <= '0;
            row_idx_q   <= '0;
            row_q       <= ~ROWS'(1);
            snap_q      <= '0;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= dwell_last && row_last;
            if (dwell_last) begin
                dwell_q                        <= '0;
                snap_q[row_idx_q*COLS +: COLS] <= ~col_s2_q;
                row_idx_q                      <= row_next;
                row_q                          <= ~(ROWS'(1) << row_next);
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    kp_debounce #(
        .W        (KEYS_N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk_i       (CLK100MHZ),
        .rst_i       (CPU_RESET),
        .snap_i      (snap_q),
        .frame_end_i (frame_end_q),
        .deb_o       (deb)
    );

    // Zero-extend the debounced matrix for the shared helpers.
    always_comb begin
        deb_ext             = '0;
        deb_ext[KEYS_N-1:0] = deb;
    end

    assign n_down   = kp_popcount(deb_ext);
    assign down_idx = kp_low_index(deb_ext);

    // Press classifier: only a lone key seen from the all-up state is reported.
    always_comb begin
        state_d = state_q;
        press   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (n_down == 1) begin
                    state_d = ST_PRESSED;
                    press   = 1'b1;
                end else if (n_down > 1) begin
                    state_d = ST_MULTI;
                end
            end
            ST_PRESSED: begin
                if (n_down == 0)     state_d = ST_IDLE;
                else if (n_down > 1) state_d = ST_MULTI;
            end
            ST_MULTI: begin
                if (n_down == 0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Classifier state register.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    assign accept = valid_q && key_ready;

    // One-deep output slot; a press finding the slot full and not being
    // drained this cycle is lost and flagged until reset.
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (press) begin
            if (!valid_q || accept) begin
                code_q  <= KW'(down_idx);
                valid_q <= 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (accept) begin
            valid_q <= 1'b0;
        end
    end

    assign ROW       = row_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign multi     = (state_q == ST_MULTI);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames).
// Frames are tracked from reset release: offset 0..15, frame end at 15.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SD = 4;
    localparam int DB = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       row;
    logic [3:0]       col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ready = 1'b0;
    logic             multi;
    logic             overflow;
    logic [15:0]      keys = '0;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    // Keypad: a closed key shorts its column to its row when that row is low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(DB)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESET (rst),
        .ROW       (row),
        .COL       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .multi     (multi),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    // Reset for 3 edges, check reset values; returns at offset 0 of frame 1.
    task automatic do_reset();
        rst       = 1'b1;
        key_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row",   row, 4'hE);
        chk("rst_valid", key_valid, 0);
        chk("rst_code",  key_code, 0);
        chk("rst_multi", multi, 0);
        chk("rst_ovf",   overflow, 0);
        rst = 1'b0;
    endtask

    // One frame from offset 0 to offset 0 of the next; ready pulses at
    // rdy_off (0 = never); optional output check at offset 12.
    task automatic run_frame(input logic [15:0] k, input int rdy_off, input bit do_chk,
                             input int ev, input int ec, input int em, input int eo,
                             input string nm);
        keys = k;
        for (int o = 1; o < 16; o++) begin
            @(negedge clk);
            key_ready = (o == rdy_off);
            if (do_chk && o == 12) begin
                chk({nm, "_valid"}, key_valid, ev);
                chk({nm, "_code"},  key_code, ec);
                chk({nm, "_multi"}, multi, em);
                chk({nm, "_ovf"},   overflow, eo);
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] k;
        int          frames;
        int          rdy_off;
        int          v;
        int          code;
        int          m;
        int          o;
    } vec_t;

    vec_t tbl[16];

    // Reference model, frame granularity: a snapshot is the key set of a frame.
    logic [15:0] m_hist[$];
    logic [15:0] m_deb;
    int          m_valid, m_code, m_multi, m_ovf;

    function automatic void model_reset();
        m_hist.delete();
        m_hist.push_back(16'h0);
        m_deb   = '0;
        m_valid = 0;
        m_code  = 0;
        m_multi = 0;
        m_ovf   = 0;
    endfunction

    // Effect of one completed frame, as seen by the outputs in the next frame.
    function automatic void model_eval(input logic [15:0] snap);
        logic [15:0] nd;
        bit          stable;
        int          pop;
        m_hist.push_back(snap);
        if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
        stable = (m_hist.size() == DB + 1);
        foreach (m_hist[i]) if (m_hist[i] != snap) stable = 0;
        nd  = stable ? snap : m_deb;
        pop = $countones(nd);
        if (m_deb == 0 && pop == 1) begin
            if (m_valid == 0) begin
                m_valid = 1;
                for (int i = 0; i < 16; i++) if (nd[i]) m_code = i;
            end else begin
                m_ovf = 1;
            end
        end
        m_multi = (pop > 1 || (m_multi != 0 && nd != 0)) ? 1 : 0;
        m_deb   = nd;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int early;
        int extra;
        logic [15:0] prev_k;
        logic [15:0] k;
        bit have_prev;

        tbl[0]  = '{16'h0200, 5, 0, 1, 9,  0, 0};  // key 9 reported
        tbl[1]  = '{16'h0200, 1, 8, 0, 9,  0, 0};  // accepted
        tbl[2]  = '{16'h0200, 2, 0, 0, 9,  0, 0};  // held: no repeat
        tbl[3]  = '{16'h0000, 4, 0, 0, 9,  0, 0};
        tbl[4]  = '{16'h0021, 4, 0, 0, 9,  1, 0};  // keys 0+5: multi
        tbl[5]  = '{16'h0001, 4, 0, 0, 9,  1, 0};  // back to one key: silent
        tbl[6]  = '{16'h0000, 4, 0, 0, 9,  0, 0};
        tbl[7]  = '{16'h0008, 4, 0, 1, 3,  0, 0};  // key 3 pending
        tbl[8]  = '{16'h0000, 4, 0, 1, 3,  0, 0};
        tbl[9]  = '{16'h0040, 4, 1, 1, 6,  0, 0};  // accept + new press same cycle
        tbl[10] = '{16'h0000, 4, 8, 0, 6,  0, 0};
        tbl[11] = '{16'h0008, 4, 0, 1, 3,  0, 0};
        tbl[12] = '{16'h0000, 4, 0, 1, 3,  0, 0};
        tbl[13] = '{16'h1000, 4, 0, 1, 3,  0, 1};  // key 12 dropped
        tbl[14] = '{16'h0000, 4, 8, 0, 3,  0, 1};  // drain, overflow sticky
        tbl[15] = '{16'h1000, 4, 0, 1, 12, 0, 1};

        // Reset and row scan sequence.
        keys = '0;
        do_reset();
        for (int o = 0; o < 16; o++) begin
            if (o % 4 == 0 || o % 4 == 3)
                chk("row_scan", row, 4'hF ^ (4'h1 << (o / 4)));
            @(negedge clk);
        end

        // Directed table.
        foreach (tbl[i]) begin
            for (int f = 0; f < tbl[i].frames; f++) begin
                bit last;
                last = (f == tbl[i].frames - 1);
                run_frame(tbl[i].k, last ? tbl[i].rdy_off : 0, last,
                          tbl[i].v, tbl[i].code, tbl[i].m, tbl[i].o,
                          $sformatf("tbl%0d", i));
            end
        end

        // Reset while a code is pending and key 9 is held.
        keys = 16'h0200;
        repeat (5) @(negedge clk);
        do_reset();
        repeat (3) run_frame(16'h0200, 0, 0, 0, 0, 0, 0, "");
        @(negedge clk);
        chk("rereport_early", key_valid, 0);
        @(negedge clk);
        chk("rereport_valid", key_valid, 1);
        chk("rereport_code",  key_code, 9);

        // Bounce: key 9 toggles every 10 cycles for 4 frames, then steady.
        do_reset();
        repeat (4) @(negedge clk);
        early = 0;
        for (int i = 0; i < 64; i++) begin
            keys = ((i / 10) % 2 == 0) ? 16'h0200 : 16'h0000;
            @(negedge clk);
            if (key_valid) early++;
        end
        keys = 16'h0200;
        repeat (45) begin
            @(negedge clk);
            if (key_valid) early++;
        end
        chk("bounce_early", early, 0);
        @(negedge clk);
        chk("bounce_valid", key_valid, 1);
        chk("bounce_code",  key_code, 9);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        extra = 0;
        repeat (48) begin
            @(negedge clk);
            if (key_valid) extra++;
        end
        chk("bounce_single_event", extra, 0);

        // Randomized frames against the reference model.
        do_reset();
        model_reset();
        have_prev = 0;
        prev_k    = '0;
        for (int s = 0; s < 30; s++) begin
            int r;
            int h;
            r = $urandom_range(0, 3);
            case (r)
                0:       k = '0;
                3:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: k = 16'h1 << $urandom_range(0, 15);
            endcase
            h = $urandom_range(1, 4);
            for (int f = 0; f < h; f++) begin
                int rdy;
                if (have_prev) model_eval(prev_k);
                rdy = $urandom_range(0, 1);
                if (rdy != 0) m_valid = 0;
                run_frame(k, (rdy != 0) ? 8 : 0, 1, m_valid, m_code, m_multi, m_ovf, "rnd");
                prev_k    = k;
                have_prev = 1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
